tdm_demux_4ch: RTL and testbench
================================

TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter W, default 8, data width of each time slot and each channel output.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  a slot sample is present on in_data this cycle.
REQ-005 in_sof  input  1  start-of-frame; qualifies in_data as slot 0; ignored when in_valid=0.
REQ-006 in_data  input  W  TDM slot sample.
REQ-007 d0_out, d1_out, d2_out, d3_out  output  W each  last sample routed to channel 0..3, registered, held until overwritten.
REQ-008 d_valid  output  4  one-cycle pulse per channel; bit k marks a new value on dk_out.
REQ-009 frame_done  output  1  one-cycle pulse when slot 3 of a frame is delivered.
REQ-010 locked  output  1  1 in state LOCKED, 0 in state HUNT.
REQ-011 sync_err  output  1  sticky framing-error flag, cleared only by reset.
REQ-012 slot  output  2  index of the slot expected on the next accepted sample.

Function
REQ-013 The block SHALL be the receive-side counterpart of the 4:1 selector: it routes a serial TDM stream to four channel registers, channel chosen by an internal slot counter instead of select inputs.
REQ-014 FSM SHALL have exactly two states: HUNT and LOCKED.
REQ-015 In HUNT, in_valid=1 with in_sof=0 SHALL be discarded: no d_valid pulse, slot stays 0.
REQ-016 In HUNT, in_valid=1 with in_sof=1 SHALL write in_data to d0_out, pulse d_valid[0], set slot=1, and go to LOCKED.
REQ-017 In LOCKED, in_valid=1 with in_sof=0 and slot=k (k=1..3) SHALL write in_data to dk_out, pulse d_valid[k], and advance slot to k+1 mod 4.
REQ-018 In LOCKED, in_valid=1 with in_sof=1 and slot=0 SHALL be treated as a normal slot-0 sample (REQ-016 routing, stay LOCKED).
REQ-019 In LOCKED, in_valid=1 with in_sof=1 and slot≠0 (early SOF) SHALL set sync_err, route the sample to d0_out with d_valid[0], set slot=1, and stay LOCKED (resync).
REQ-020 In LOCKED, in_valid=1 with in_sof=0 and slot=0 (missing SOF) SHALL set sync_err, discard the sample, and go to HUNT with slot=0.
REQ-021 Cycles with in_valid=0 SHALL change no state, no data register, and produce no pulses; gaps between slots are legal.
REQ-022 Latency: a sample accepted in cycle n SHALL appear on dk_out and d_valid[k] in cycle n+1; d_valid SHALL be one-hot or zero.
REQ-023 frame_done SHALL pulse in the same cycle as d_valid[3], and only then.
REQ-024 Slot counter SHALL wrap from 3 to 0 after slot 3 is delivered; the following sample requires in_sof=1.
REQ-025 Non-addressed channel outputs SHALL hold their values across any accepted sample or discard.
REQ-026 The block SHALL always accept input; it has no backpressure.

Reset
REQ-027 With rst_n=0 at a rising edge, next cycle: state HUNT, slot=0, d0_out..d3_out=0, d_valid=0, frame_done=0, locked=0, sync_err=0.
REQ-028 Reset SHALL take priority over in_valid in the same cycle; a mid-frame reset discards the partial frame, and the next frame requires in_sof.
REQ-029 Reset SHALL NOT act asynchronously; outputs change only on a rising clk edge.

Verification
REQ-030 Scenario: reset, then samples A1/B2/C3/D4 (in_sof only on A1), W=8, back-to-back -> d0..d3 = A1,B2,C3,D4, one per cycle; d_valid 0001,0010,0100,1000; frame_done with D4; sync_err=0.
REQ-031 Scenario: 5 samples with in_sof=0 after reset -> no d_valid; locked=0; slot=0; outputs stay 00.
REQ-032 Scenario: SOF+11, 22, then SOF+33 (early) -> d0_out=33, sync_err=1, slot=1, locked=1; d2_out and d3_out unchanged.
REQ-033 Scenario: full frame, then next sample 55 with in_sof=0 -> sample dropped, sync_err=1, locked=0; a following SOF+66 gives d0_out=66, locked=1.
REQ-034 Scenario: frame with 3 idle cycles between each slot -> same outputs as REQ-030; no pulses during idles.
REQ-035 Scenario: rst_n=0 asserted after slot 1 with in_valid=1 that cycle -> sample ignored; all outputs 0, locked=0, sync_err=0.

Source files
------------

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: routes a serial 4-slot TDM stream to four registered channel outputs.
// Framing is tracked by a HUNT/LOCKED FSM; in_sof marks slot 0.
module tdm_demux_4ch #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic         in_sof,
   input  logic [W-1:0] in_data,
   output logic [W-1:0] d0_out,
   output logic [W-1:0] d1_out,
   output logic [W-1:0] d2_out,
   output logic [W-1:0] d3_out,
   output logic [3:0]   d_valid,
   output logic         frame_done,
   output logic         locked,
   output logic         sync_err,
   output logic [1:0]   slot
);
   typedef enum logic {HUNT, LOCKED} state_t;
   state_t     state, nxt_state;
   logic [1:0] nxt_slot;
   logic [1:0] wr_ch;
   logic       wr;
   logic       err;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= HUNT;
         slot  <= 2'd0;
      end else begin
         state <= nxt_state;
         slot  <= nxt_slot;
      end
   end
   // An SOF always resyncs to slot 1; it is an error only if it arrives mid-frame.
   always_comb begin
      nxt_state = state;
      nxt_slot  = slot;
      wr        = 1'b0;
      wr_ch     = slot;
      err       = 1'b0;
      if (in_valid && in_sof) begin
         nxt_state = LOCKED;
         nxt_slot  = 2'd1;
         wr        = 1'b1;
         wr_ch     = 2'd0;
         err       = state == LOCKED && slot != 2'd0;
      end else if (in_valid && state == LOCKED) begin
         nxt_state = slot == 2'd0 ? HUNT : LOCKED;
         err       = slot == 2'd0;
         wr        = slot != 2'd0;
         nxt_slot  = slot == 2'd0 ? 2'd0 : slot + 2'd1;
      end
   end
   always_comb locked = state == LOCKED;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d0_out     <= '0;
         d1_out     <= '0;
         d2_out     <= '0;
         d3_out     <= '0;
         d_valid    <= 4'b0000;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         d0_out     <= wr && wr_ch == 2'd0 ? in_data : d0_out;
         d1_out     <= wr && wr_ch == 2'd1 ? in_data : d1_out;
         d2_out     <= wr && wr_ch == 2'd2 ? in_data : d2_out;
         d3_out     <= wr && wr_ch == 2'd3 ? in_data : d3_out;
         d_valid    <= wr ? 4'b0001 << wr_ch : 4'b0000;
         frame_done <= wr && wr_ch == 2'd3;
         sync_err   <= sync_err | err;
      end
   end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: scoreboard bench; a behavioural frame model queues the expected
// outputs for each driven cycle and they are compared one cycle later.
module tb_tdm_demux_4ch;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_sof = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [7:0] d0_out, d1_out, d2_out, d3_out;
   logic [3:0] d_valid;
   logic       frame_done, locked, sync_err;
   logic [1:0] slot;
   typedef struct {
      logic [7:0] d [4];
      logic [3:0] dv;
      logic       fd;
      logic       lk;
      logic       er;
      logic [1:0] sl;
   } exp_t;
   exp_t       q[$];
   logic [7:0] m_d [4];
   logic       m_lock, m_err;
   int         m_slot;
   int         checks = 0;
   int         errors = 0;
   tdm_demux_4ch #(.W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .d0_out(d0_out), .d1_out(d1_out), .d2_out(d2_out), .d3_out(d3_out),
      .d_valid(d_valid), .frame_done(frame_done), .locked(locked),
      .sync_err(sync_err), .slot(slot)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic rst, input logic v, input logic sof, input logic [7:0] data);
      exp_t e;
      logic [3:0] dv;
      logic       fd;
      dv = 4'b0000;
      fd = 1'b0;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_d[i] = 8'h00;
         m_lock = 1'b0;
         m_err  = 1'b0;
         m_slot = 0;
      end else if (v && sof) begin
         if (m_lock && m_slot != 0) m_err = 1'b1;
         m_d[0] = data;
         dv     = 4'b0001;
         m_slot = 1;
         m_lock = 1'b1;
      end else if (v && m_lock) begin
         if (m_slot == 0) begin
            m_err  = 1'b1;
            m_lock = 1'b0;
         end else begin
            m_d[m_slot] = data;
            dv          = 4'(1 << m_slot);
            fd          = m_slot == 3;
            m_slot      = (m_slot + 1) % 4;
         end
      end
      e.d  = m_d;
      e.dv = dv;
      e.fd = fd;
      e.lk = m_lock;
      e.er = m_err;
      e.sl = 2'(m_slot);
      q.push_back(e);
      rst_n    = ~rst;
      in_valid = v;
      in_sof   = sof;
      in_data  = data;
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("d0", 32'(d0_out), 32'(e.d[0]));
      chk("d1", 32'(d1_out), 32'(e.d[1]));
      chk("d2", 32'(d2_out), 32'(e.d[2]));
      chk("d3", 32'(d3_out), 32'(e.d[3]));
      chk("d_valid", 32'(d_valid), 32'(e.dv));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      chk("locked", 32'(locked), 32'(e.lk));
      chk("sync_err", 32'(sync_err), 32'(e.er));
      chk("slot", 32'(slot), 32'(e.sl));
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
   endtask
   initial begin
      step(1'b1, 1'b1, 1'b1, 8'hEE);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'hA1);
      step(1'b0, 1'b1, 1'b0, 8'hB2);
      step(1'b0, 1'b1, 1'b0, 8'hC3);
      step(1'b0, 1'b1, 1'b0, 8'hD4);
      chk("frame_d3", 32'(d3_out), 32'h0000_00D4);
      chk("frame_done_with_d4", 32'(frame_done), 32'h1);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
      chk("hunt_locked", 32'(locked), 32'h0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h11);
      step(1'b0, 1'b1, 1'b0, 8'h22);
      step(1'b0, 1'b1, 1'b1, 8'h33);
      chk("early_sof_d0", 32'(d0_out), 32'h33);
      chk("early_sof_err", 32'(sync_err), 32'h1);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h01);
      step(1'b0, 1'b1, 1'b0, 8'h02);
      step(1'b0, 1'b1, 1'b0, 8'h03);
      step(1'b0, 1'b1, 1'b0, 8'h04);
      step(1'b0, 1'b1, 1'b0, 8'h55);
      chk("missing_sof_locked", 32'(locked), 32'h0);
      step(1'b0, 1'b1, 1'b1, 8'h66);
      chk("relock_d0", 32'(d0_out), 32'h66);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'hA1);
      idle(3);
      step(1'b0, 1'b1, 1'b0, 8'hB2);
      idle(3);
      step(1'b0, 1'b1, 1'b0, 8'hC3);
      idle(3);
      step(1'b0, 1'b1, 1'b0, 8'hD4);
      idle(3);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h77);
      step(1'b0, 1'b1, 1'b0, 8'h88);
      step(1'b1, 1'b1, 1'b0, 8'h99);
      chk("mid_reset_d1", 32'(d1_out), 32'h0);
      step(1'b0, 1'b1, 1'b0, 8'hAA);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0, 8'($urandom));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
